multicycle_control: RTL and testbench

- Main control FSM of the multicycle RV32I core; sits directly upstream of the ALU.
- Decodes op/funct fields from the instruction register and drives the ALU's 4-bit alu_control, its operand selects and all datapath write enables.
- Consumes the ALU zero flag for branch resolution.
- Handshakes with the unified instruction/data memory through mem_ready.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/alu_decoder.sv | 46 ++++
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, ALU
// operation codes, opcodes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
  } state_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps alu_op plus funct fields to the 4-bit ALU
// code, and flags the reserved branch funct3 encodings (01x).
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_control,
  output logic       branch_illegal
);

  always_comb begin
    alu_control    = ALU_ADD;
    branch_illegal = 1'b0;
    case (alu_op)
      ALUOP_BRANCH: begin
        case (funct3[2:1])
          2'b00:   alu_control = ALU_SUB;
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: begin
            alu_control    = ALU_SUB;
            branch_illegal = 1'b1;
          end
        endcase
      end
      ALUOP_FUNCT: begin
        // op5 separates R-type from OP-IMM, so addi never becomes SUB
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core. Optional performance
// counters (cycle_count, instret_count) are built when CTRL_PERF_EN is defined.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_src,
  output logic [3:0]  alu_control,
  output logic        illegal
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       rdy;
  logic [1:0] alu_op;
  logic       branch_illegal;
  logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;

  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .op5           (op[5]),
    .alu_control   (alu_control),
    .branch_illegal(branch_illegal)
  );

  always_comb begin
    case (op)
      OP_STORE:          imm_src = IMM_S;
      OP_BRANCH:         imm_src = IMM_B;
      OP_LUI, OP_AUIPC:  imm_src = IMM_U;
      OP_JAL:            imm_src = IMM_J;
      default:           imm_src = IMM_I;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    adr_src     = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (rdy) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_RDATA;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_BRANCH;
        pc_write_c = ~branch_illegal & (zero ^ funct3[0] ^ funct3[2]);
        state_d    = branch_illegal ? S_TRAP : S_FETCH;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = S_JAL;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are masked during reset so nothing commits while it is asserted
  assign pc_write  = pc_write_c  & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign ir_write  = ir_write_c  & ~reset;
  assign reg_write = reg_write_c & ~reset;

  assign illegal_d = illegal_q | (state_d == S_TRAP);
  assign illegal   = illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_q, cycle_d, instret_q, instret_d;

  always_comb begin
    cycle_d   = (state_q != S_TRAP) ? cycle_q + 32'd1 : cycle_q;
    instret_d = ((state_d == S_FETCH) && (state_q != S_FETCH)) ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: each instruction's
// expected per-cycle control vector is built from the instruction class.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_count, instret_count;
`endif

  multicycle_control #(.MEM_HANDSHAKE(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal)
`ifdef CTRL_PERF_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model_cyc = 0;
  int model_ret = 0;

  logic [15:0] obs;
  assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_control, illegal};

  function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [3:0] alu, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, ill};
  endfunction

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [15:0] FETCH_W  = {5'b00000, 2'b10, 2'b00, 2'b10, 4'b0010, 1'b0};
  localparam logic [15:0] FETCH_GO = {5'b10010, 2'b10, 2'b00, 2'b10, 4'b0010, 1'b0};
  localparam logic [15:0] TRAP_V   = {5'b00000, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b1};

  function automatic logic [2:0] ref_imm(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b0110111, 7'b0010111: return 3'b011;
      7'b1101111:             return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] ref_funct(input logic [2:0] f3, input logic f7, input bit rtype);
    case (f3)
      3'd0:    return (rtype && f7) ? 4'b0110 : 4'b0010;
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b1111;
      3'd4:    return 4'b1010;
      3'd5:    return f7 ? 4'b0011 : 4'b1001;
      3'd6:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at posedge+1, sample at the falling edge.
  task automatic step_m(input string tag, input logic [15:0] exp, input logic [15:0] mask,
                        input logic mr, input logic z, input bit last);
    mem_ready = mr;
    zero = z;
    #4;
    check(tag, 32'(obs & mask), 32'(exp & mask));
    check({tag, "_imm"}, 32'(imm_src), 32'(ref_imm(op)));
`ifdef CTRL_PERF_EN
    check({tag, "_cyc"}, cycle_count, 32'(model_cyc));
    check({tag, "_ret"}, instret_count, 32'(model_ret));
`endif
    @(posedge clk);
    #1;
    if (!exp[0]) model_cyc++;
    if (last) model_ret++;
  endtask

  task automatic step(input string tag, input logic [15:0] exp, input logic mr,
                      input logic z, input bit last);
    step_m(tag, exp, 16'hFFFF, mr, z, last);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with reset released.
  task automatic apply_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    #2;
    check("rst_vec", 32'(obs), 32'(FETCH_W));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_cyc = 0;
    model_ret = 0;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fw, input int mw, input logic bz);
    logic [15:0] aluwb, memadr, jalv;
    op = o; funct3 = f3; funct7b5 = f7;
    aluwb  = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, 0);
    memadr = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, 0);
    jalv   = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, ADD, 0);
    for (int i = 0; i < fw; i++) step("fetch_wait", FETCH_W, 1'b0, rbit(), 0);
    step("fetch", FETCH_GO, 1'b1, rbit(), 0);
    step("decode", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD, 0), rbit(), rbit(), 0);
    case (o)
      7'b0000011: begin
        step("memadr", memadr, rbit(), rbit(), 0);
        for (int i = 0; i < mw; i++)
          step("memread_wait", mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 0), 1'b0, rbit(), 0);
        step("memread", mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 0), 1'b1, rbit(), 0);
        step("memwb", mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, ADD, 0), rbit(), rbit(), 1);
      end
      7'b0100011: begin
        step("memadr", memadr, rbit(), rbit(), 0);
        for (int i = 0; i < mw; i++)
          step("memwrite_wait", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 0), 1'b0, rbit(), 0);
        step("memwrite", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 0), 1'b1, rbit(), 1);
      end
      7'b0110011: begin
        step("execr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ref_funct(f3, f7, 1), 0), rbit(), rbit(), 0);
        step("aluwb", aluwb, rbit(), rbit(), 1);
      end
      7'b0010011: begin
        step("execi", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ref_funct(f3, f7, 0), 0), rbit(), rbit(), 0);
        step("aluwb", aluwb, rbit(), rbit(), 1);
      end
      7'b1100011: begin
        step("branch", mk(bz ^ f3[0] ^ f3[2], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00,
                          f3[2] ? (f3[1] ? 4'b1111 : 4'b0111) : 4'b0110, 0), rbit(), bz, 1);
      end
      7'b1101111: begin
        step("jal", jalv, rbit(), rbit(), 0);
        step("aluwb", aluwb, rbit(), rbit(), 1);
      end
      7'b1100111: begin
        step("jalr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, 0), rbit(), rbit(), 0);
        step("jal", jalv, rbit(), rbit(), 0);
        step("aluwb", aluwb, rbit(), rbit(), 1);
      end
      7'b0110111: begin
        step("lui", mk(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, ADD, 0), rbit(), rbit(), 0);
        step("aluwb", aluwb, rbit(), rbit(), 1);
      end
      7'b0010111: step("aluwb", aluwb, rbit(), rbit(), 1);
      default: begin
        for (int i = 0; i < 3; i++) step("trap", TRAP_V, rbit(), rbit(), 0);
      end
    endcase
  endtask

  logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    logic [2:0] f3;
    #1;
    apply_reset();

    // Three back-to-back addi: 12 cycles, 3 retirements
    for (int i = 0; i < 3; i++) run_instr(7'b0010011, 3'b000, 1'b0, 0, 0, 1'b0);
`ifdef CTRL_PERF_EN
    #4;
    check("perf_cycles", cycle_count, 32'd12);
    check("perf_instret", instret_count, 32'd3);
    @(posedge clk);
    #1;
    model_cyc++;
`endif

    run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0);   // add
    run_instr(7'b0110011, 3'b000, 1'b1, 1, 0, 1'b0);   // sub
    run_instr(7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0);   // addi, f7b5 set
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, 1'b0);   // lw, 3 wait cycles
    run_instr(7'b1100011, 3'b101, 1'b0, 0, 0, 1'b1);   // bge taken
    run_instr(7'b1100011, 3'b101, 1'b0, 0, 0, 1'b0);   // bge not taken
    run_instr(7'b1100011, 3'b110, 1'b0, 0, 0, 1'b0);   // bltu taken
    run_instr(7'b1100111, 3'b000, 1'b0, 0, 0, 1'b0);   // jalr

    for (int n = 0; n < 60; n++) begin
      logic [6:0] o;
      o  = legal_ops[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      if (o == 7'b1100011 && f3[2:1] == 2'b01) f3[2] = 1'b1;
      run_instr(o, f3, rbit(), $urandom_range(0, 2), $urandom_range(0, 3), rbit());
    end

    // Reset in the middle of a stalled store
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    step("sw_fetch", FETCH_GO, 1'b1, 1'b0, 0);
    step("sw_decode", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD, 0), 1'b0, 1'b0, 0);
    step("sw_memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, 0), 1'b0, 1'b0, 0);
    mem_ready = 1'b0;
    #4;
    check("sw_stall_mw", 32'(mem_write), 32'd1);
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_mw", 32'(mem_write), 32'd0);
    check("rst_pcw", 32'(pc_write), 32'd0);
    check("rst_irw", 32'(ir_write), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_cyc = 0;
    model_ret = 0;
    run_instr(7'b0110011, 3'b111, 1'b0, 0, 0, 1'b0);

    // Unknown opcode traps; illegal holds until reset
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0);
    apply_reset();
    run_instr(7'b0010011, 3'b100, 1'b0, 0, 0, 1'b0);

    // Reserved branch funct3 goes to TRAP without redirecting the PC
    op = 7'b1100011; funct3 = 3'b010; funct7b5 = 1'b0;
    step("bill_fetch", FETCH_GO, 1'b1, 1'b0, 0);
    step("bill_decode", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD, 0), 1'b0, 1'b0, 0);
    step_m("bill_branch", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b0000, 0), 16'hFFE1, 1'b1, 1'b1, 0);
    step("bill_trap", TRAP_V, 1'b1, 1'b0, 0);
    step("bill_trap", TRAP_V, 1'b1, 1'b1, 0);
    apply_reset();
    run_instr(7'b0110111, 3'b000, 1'b0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
